// File: rtl/cla_sub16_pipe.sv
// cla_sub16_pipe: two-stage pipelined 16-bit subtractor, Diff = A - B - bin.
// Computed as A + ~B + ~bin on a hierarchical carry-lookahead structure
// (bit P/G -> 4-bit block P/G -> block carries -> in-block lookahead).
// Valid/ready on both sides; in_ready depends combinationally on out_ready.
// Optional flags (Zero, Ovf, Neg) are enabled by defining CLA_SUB16_FLAGS_EN.

module cla_sub16_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Diff,
    output logic        Bout
`ifdef CLA_SUB16_FLAGS_EN
    ,
    output logic        Zero,
    output logic        Ovf,
    output logic        Neg
`endif
);

    // ---------------- Flow control ----------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s1_adv;
    logic s2_adv;

    // Stage advance conditions; in_ready is the only comb input-to-output path.
    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // ---------------- Stage 1: bit and block P/G ----------------
    logic [15:0] bi;
    logic [15:0] p_d;
    logic [15:0] g_d;
    logic [3:0]  pk_d;
    logic [3:0]  gk_d;

    // Bit propagate/generate over A and the inverted subtrahend.
    always_comb begin
        bi  = ~B;
        p_d = A ^ bi;
        g_d = A & bi;
    end

    for (genvar k = 0; k < 4; k++) begin : g_blk_pg
        assign pk_d[k] = &p_d[4*k +: 4];
        assign gk_d[k] = g_d[4*k+3]
                       | (p_d[4*k+3] & g_d[4*k+2])
                       | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                       | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end

    logic [15:0] p_q;
    logic [15:0] g_q;
    logic [3:0]  pk_q;
    logic [3:0]  gk_q;
    logic        c0_q;
`ifdef CLA_SUB16_FLAGS_EN
    logic        a15_q;
    logic        bi15_q;
`endif

    // Stage 1 register: captures an operand beat whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            pk_q       <= '0;
            gk_q       <= '0;
            c0_q       <= 1'b0;
`ifdef CLA_SUB16_FLAGS_EN
            a15_q      <= 1'b0;
            bi15_q     <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q    <= p_d;
                g_q    <= g_d;
                pk_q   <= pk_d;
                gk_q   <= gk_d;
                c0_q   <= ~bin;
`ifdef CLA_SUB16_FLAGS_EN
                a15_q  <= A[15];
                bi15_q <= bi[15];
`endif
            end
        end
    end

    // ---------------- Stage 2: carries and sum ----------------
    logic [4:0]  blk_c;
    logic [15:0] carry;
    logic [15:0] diff_d;
    logic        bout_d;

    assign blk_c[0] = c0_q;

    for (genvar k = 0; k < 4; k++) begin : g_blk_sum
        // Block carry chain; blk_c[4] is the final carry-out.
        assign blk_c[k+1] = gk_q[k] | (pk_q[k] & blk_c[k]);

        // In-block lookahead from the block carry-in.
        assign carry[4*k]   = blk_c[k];
        assign carry[4*k+1] = g_q[4*k] | (p_q[4*k] & blk_c[k]);
        assign carry[4*k+2] = g_q[4*k+1]
                            | (p_q[4*k+1] & g_q[4*k])
                            | (p_q[4*k+1] & p_q[4*k] & blk_c[k]);
        assign carry[4*k+3] = g_q[4*k+2]
                            | (p_q[4*k+2] & g_q[4*k+1])
                            | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                            | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & blk_c[k]);
    end

    // Sum and borrow-out; a borrow is the absence of a carry out.
    always_comb begin
        diff_d = p_q ^ carry;
        bout_d = ~blk_c[4];
    end

`ifdef CLA_SUB16_FLAGS_EN
    logic zero_d;
    logic ovf_d;
    logic neg_d;

    // Flags derived from the stage 2 sum and the stored operand sign bits.
    always_comb begin
        zero_d = ~|diff_d;
        neg_d  = diff_d[15];
        ovf_d  = (a15_q ^ ~bi15_q) & (a15_q ^ diff_d[15]);
    end
`endif

    logic [15:0] diff_q;
    logic        bout_q;
`ifdef CLA_SUB16_FLAGS_EN
    logic        zero_q;
    logic        ovf_q;
    logic        neg_q;
`endif

    // Output register: holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
`ifdef CLA_SUB16_FLAGS_EN
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
`ifdef CLA_SUB16_FLAGS_EN
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
                neg_q  <= neg_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
`ifdef CLA_SUB16_FLAGS_EN
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;
    assign Neg       = neg_q;
`endif

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Scoreboard bench for cla_sub16_pipe. The driver pushes the expected result
// of every accepted beat; a monitor pops and compares on each output transfer.
// Flag checks are compiled in when CLA_SUB16_FLAGS_EN is defined.

module tb_cla_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Diff;
    logic        Bout;
`ifdef CLA_SUB16_FLAGS_EN
    logic        Zero;
    logic        Ovf;
    logic        Neg;
`endif

    cla_sub16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef CLA_SUB16_FLAGS_EN
        ,
        .Zero      (Zero),
        .Ovf       (Ovf),
        .Neg       (Neg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic        zero;
        logic        ovf;
        logic        neg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: 1,0,0,1,1 pattern, 2: random, 3: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic z,
                                input logic o, input logic n);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.zero = z;
        e.ovf  = o;
        e.neg  = n;
        return e;
    endfunction

    // Reference: plain 17-bit subtraction, borrow from the sign of the result.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - {16'b0, bi};
        return mk(r[15:0], r[16], (r[15:0] == 16'h0000), (a[15] ^ b[15]) & (a[15] ^ r[15]),
                  r[15]);
    endfunction

    // Present one beat, hold until accepted, then record its expected result.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input exp_t e);
        int guard;
        guard = 0;
        @(negedge clk);
        A        = a;
        B        = b;
        bin      = bi;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 500) begin
                checks++;
                errors++;
                $display("FAIL send timeout: in_ready 0 for %0d cycles, required 1", guard);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    // Consumer readiness, changed only on falling edges.
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cnt % 5) != 1) && ((cnt % 5) != 2);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            cnt++;
        end
    end

    // Monitor: samples just before each rising edge.
    initial begin
        exp_t        e;
        logic        stall;
        logic [15:0] sd;
        logic        sb;
        stall = 1'b0;
        sd    = '0;
        sb    = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall out_valid", out_valid, 1);
                    check("stall Diff", Diff, sd);
                    check("stall Bout", Bout, sb);
                end
                // Two outstanding beats means both stages are full.
                check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected beat: got Diff %0h, required no beat", Diff);
                    end else begin
                        e = exp_q.pop_front();
                        check("Diff", Diff, e.diff);
                        check("Bout", Bout, e.bout);
`ifdef CLA_SUB16_FLAGS_EN
                        check("Zero", Zero, e.zero);
                        check("Ovf", Ovf, e.ovf);
                        check("Neg", Neg, e.neg);
`endif
                    end
                end
                stall = out_valid && !out_ready;
                sd    = Diff;
                sb    = Bout;
            end
        end
    end

    initial begin
        exp_t r;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;

        // Reset release after three low cycles.
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset Diff", Diff, 16'h0000);
        check("reset Bout", Bout, 0);
        check("reset in_ready", in_ready, 1);
`ifdef CLA_SUB16_FLAGS_EN
        check("reset flags", {Zero, Ovf, Neg}, 3'b000);
`endif

        // Single beat: captured into stage 1, result registered on the next edge.
        send(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 0, 0, 0, 0));
        idle();
        #1;
        check("latency stage1", out_valid, 0);
        @(negedge clk);
        #1;
        check("latency stage2", out_valid, 1);
        drain();

        // Directed vectors, back to back.
        send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 0, 1));
        send(16'h8000, 16'h0000, 1'b1, mk(16'h7FFF, 0, 0, 1, 0));
        send(16'hABCD, 16'hABCC, 1'b1, mk(16'h0000, 0, 1, 0, 0));
        send(16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1, 1, 0, 0));
        send(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 0, 1, 1));
        send(16'hFFFF, 16'h0001, 1'b0, mk(16'hFFFE, 0, 0, 0, 1));
        send(16'h5555, 16'hAAAA, 1'b0, mk(16'hAAAB, 1, 0, 1, 1));
        send(16'h0000, 16'h0000, 1'b1, mk(16'hFFFF, 1, 0, 0, 1));
        idle();
        drain();

        // Streaming under the 1,0,0,1,1 backpressure pattern.
        rdy_mode = 1;
        send(16'h0010, 16'h0001, 1'b0, mk(16'h000F, 0, 0, 0, 0));
        send(16'h0100, 16'h0010, 1'b0, mk(16'h00F0, 0, 0, 0, 0));
        send(16'h1000, 16'h0100, 1'b0, mk(16'h0F00, 0, 0, 0, 0));
        send(16'hF000, 16'h1000, 1'b0, mk(16'hE000, 0, 0, 0, 1));
        send(16'h00FF, 16'h00FF, 1'b0, mk(16'h0000, 0, 1, 0, 0));
        idle();
        drain();

        // Fill both stages with the consumer stalled, then reset mid-stream.
        rdy_mode = 3;
        send(16'h1111, 16'h0001, 1'b0, mk(16'h1110, 0, 0, 0, 0));
        send(16'h2222, 16'h0002, 1'b0, mk(16'h2220, 0, 0, 0, 0));
        idle();
        #1;
        check("full in_ready", in_ready, 0);
        check("full out_valid", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        check("post-reset out_valid", out_valid, 0);
        check("post-reset Diff", Diff, 16'h0000);
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("flushed beat absent", out_valid, 0);
        end

        // Model cross-check with random operands and random readiness.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            r   = model(ra, rb, rbi);
            send(ra, rb, rbi, r);
        end
        idle();
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
